mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

Request-side controller that drives one port of the dual-port main-memory block RAM (synchronous read, one-cycle read latency, read-first on write). Two clients share the port: a CPU client doing single-word reads and writes, and a stream client doing auto-incrementing burst reads for display/DMA fetch. The controller arbitrates, generates RAM addresses, tracks read latency and returns tagged read data to the correct client.

## Interface
- DATA, 18, word width, matches RAM port width
- ADDR, 14, address width, matches RAM port address width
- LEN, 8, burst length counter width

- clka  in  1  sole clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- c0_req  in  1  CPU access request, held until granted
- c0_we  in  1  1 = write, 0 = read
- c0_addr  in  ADDR  CPU word address
- c0_wdata  in  DATA  CPU write data
- c0_gnt  out  1  combinational; request issued to RAM this cycle
- c0_rvalid  out  1  one-cycle pulse; c0_rdata valid
- c0_rdata  out  DATA  CPU read data, held until next c0_rvalid
- c1_start  in  1  one-cycle burst start pulse
- c1_addr  in  ADDR  burst base address, sampled with c1_start
- c1_len  in  LEN  burst word count, sampled with c1_start
- c1_busy  out  1  high from cycle after accepted start until cycle after c1_done
- c1_valid  out  1  one-cycle pulse per returned burst word
- c1_data  out  DATA  burst word, in address order
- c1_done  out  1  one-cycle pulse coincident with last c1_valid
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR  RAM address
- mem_din  out  DATA  RAM write data
- mem_dout  in  DATA  RAM read data, valid one cycle after address issue

## Operation
- FSM states: IDLE, BURST, DRAIN.
- IDLE: c1_start accepted -> latch base, len, issue counter = 0; len != 0 -> BURST; len == 0 -> DRAIN with no reads, c1_done pulses two cycles after start, c1_valid never asserted.
- c1_start ignored while c1_busy.
- BURST: each cycle the stream slot wins arbitration, issue read at base + k, k++; after issue k == len-1 -> DRAIN.
- DRAIN: wait for all in-flight stream reads to return, then IDLE, c1_busy drops the cycle after c1_done.
- Arbitration (per cycle): c0_req served in any state; without contention, stream issues in BURST. Contention resolution per Configuration.
- Address arithmetic modulo 2^ADDR; burst wraps 2^ADDR-1 -> 0.
- RAM port driven combinationally from winner: mem_we = c0_we only when CPU wins; mem_we = 0 otherwise and when no winner; mem_addr/mem_din = 0 when idle.
- Two-bit response pipeline (valid + owner tag) tracks each read; writes return nothing.
- Read-after-write to same address in next cycle returns new data (RAM read-first applies only to same-cycle).

## Timing
- Read issued cycle N: mem_dout valid in N+1, registered into c0_rdata/c1_data, rvalid/valid asserted in cycle N+2. Throughput one read per cycle.
- Writes complete at the edge ending the grant cycle.
- Burst of L words, no CPU traffic: start at cycle S, issues S+1..S+L, c1_valid S+3..S+L+2, c1_done at S+L+2.
- Reset: state IDLE; all outputs 0; counters 0; in-flight reads discarded (no valid pulse after reset release). Reset mid-burst aborts with no c1_done.
- c0_req and c1_start same cycle in IDLE: both accepted; CPU issues that cycle, burst issues from next cycle.

## Configuration
- MEM_REQ_RR_EN defined: round-robin on contention; stream wins if CPU won the previous contended cycle, else CPU wins. Guarantees each client at least every other contended cycle.
- Undefined: fixed priority, CPU always wins; stream stalls while c0_req held (no starvation guard).

## Test plan
- Reset, CPU write 0x2AAAA to 0x0010, read 0x0010 -> c0_gnt same cycle, c0_rvalid two cycles after read grant, c0_rdata = 0x2AAAA.
- Burst base 0x0100, len 4 on preloaded RAM (mem[a] = a) -> c1_valid four consecutive cycles, data 0x100..0x103, c1_done with 4th, c1_busy low next cycle.
- Burst base 0x3FFE, len 4 -> data from 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Burst len 8 with c0_req held 4 cycles mid-burst -> without macro: stream stalls 4 cycles, 8 words in order; with MEM_REQ_RR_EN: CPU and stream alternate, all 4 CPU reads and 8 words correct.
- Burst len 0 -> c1_done two cycles after start, no c1_valid, no RAM activity.
- Assert rst during burst len 16 after 5 words -> all outputs 0 immediately, no further c1_valid/c1_done; new start after release completes normally.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// Request-side controller for one block-RAM port: CPU single-word access plus stream bursts.
// Define MEM_REQ_RR_EN for round-robin arbitration on contention; otherwise the CPU always wins.
module mem_req_ctrl #(
    parameter int DATA = 18,
    parameter int ADDR = 14,
    parameter int LEN  = 8
) (
    input  logic            clka,
    input  logic            rst,
    input  logic            c0_req,
    input  logic            c0_we,
    input  logic [ADDR-1:0] c0_addr,
    input  logic [DATA-1:0] c0_wdata,
    output logic            c0_gnt,
    output logic            c0_rvalid,
    output logic [DATA-1:0] c0_rdata,
    input  logic            c1_start,
    input  logic [ADDR-1:0] c1_addr,
    input  logic [LEN-1:0]  c1_len,
    output logic            c1_busy,
    output logic            c1_valid,
    output logic [DATA-1:0] c1_data,
    output logic            c1_done,
    output logic            mem_we,
    output logic [ADDR-1:0] mem_addr,
    output logic [DATA-1:0] mem_din,
    input  logic [DATA-1:0] mem_dout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]      state_reg, state_next;
    logic [ADDR-1:0] addr_reg;
    logic [LEN-1:0]  len_reg;
    logic [LEN-1:0]  issue_cnt_reg;
    logic [LEN-1:0]  ret_cnt_reg;
    logic            p1_valid_reg;
    logic            p1_tag_reg;
    logic            c0_rvalid_reg;
    logic [DATA-1:0] c0_rdata_reg;
    logic            c1_valid_reg;
    logic [DATA-1:0] c1_data_reg;
    logic            c1_done_reg;
    logic            c1_done_next;

    logic            stream_want;
    logic            cpu_win;
    logic            stream_win;
    logic            start_ok;

    // Gating with rst keeps the combinational outputs at zero while reset is held.
    assign stream_want = (state_reg == BURST) && !rst;
    assign start_ok    = c1_start && (state_reg == IDLE);

`ifdef MEM_REQ_RR_EN
    logic contend;
    logic rr_stream_reg;

    assign contend = c0_req && stream_want;
    assign cpu_win = c0_req && !rst && !(stream_want && rr_stream_reg);

    // Stream gets the next contended cycle whenever the CPU took this one.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            rr_stream_reg <= 1'b0;
        end else if (contend) begin
            rr_stream_reg <= cpu_win;
        end
    end
`else
    assign cpu_win = c0_req && !rst;
`endif

    assign stream_win = stream_want && !cpu_win;
    assign c0_gnt     = cpu_win;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (cpu_win) begin
            mem_we   = c0_we;
            mem_addr = c0_addr;
            mem_din  = c0_wdata;
        end else if (stream_win) begin
            mem_addr = addr_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next = (c1_len == '0) ? DRAIN : BURST;
                end
            end
            BURST: begin
                if (stream_win && (issue_cnt_reg == len_reg - LEN'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (c1_done_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A zero-length burst still produces a single done pulse, two cycles after start.
    assign c1_done_next = (p1_valid_reg && p1_tag_reg && (ret_cnt_reg == len_reg - LEN'(1)))
                        || ((state_reg == DRAIN) && (len_reg == '0) && !c1_done_reg);

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            len_reg       <= '0;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
            p1_valid_reg  <= 1'b0;
            p1_tag_reg    <= 1'b0;
            c0_rvalid_reg <= 1'b0;
            c0_rdata_reg  <= '0;
            c1_valid_reg  <= 1'b0;
            c1_data_reg   <= '0;
            c1_done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                addr_reg      <= c1_addr;
                len_reg       <= c1_len;
                issue_cnt_reg <= '0;
                ret_cnt_reg   <= '0;
            end else begin
                if (stream_win) begin
                    addr_reg      <= addr_reg + ADDR'(1);
                    issue_cnt_reg <= issue_cnt_reg + LEN'(1);
                end
                if (p1_valid_reg && p1_tag_reg) begin
                    ret_cnt_reg <= ret_cnt_reg + LEN'(1);
                end
            end

            // Tag 1 marks a stream read; CPU writes never enter the pipeline.
            p1_valid_reg <= (cpu_win && !c0_we) || stream_win;
            p1_tag_reg   <= stream_win;

            c0_rvalid_reg <= p1_valid_reg && !p1_tag_reg;
            if (p1_valid_reg && !p1_tag_reg) begin
                c0_rdata_reg <= mem_dout;
            end
            c1_valid_reg <= p1_valid_reg && p1_tag_reg;
            if (p1_valid_reg && p1_tag_reg) begin
                c1_data_reg <= mem_dout;
            end
            c1_done_reg <= c1_done_next;
        end
    end

    assign c0_rvalid = c0_rvalid_reg;
    assign c0_rdata  = c0_rdata_reg;
    assign c1_valid  = c1_valid_reg;
    assign c1_data   = c1_data_reg;
    assign c1_done   = c1_done_reg;
    assign c1_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed tables/sequences plus random traffic
// checked against a scoreboard of a shadow memory and per-request due cycles.
`timescale 1ns/1ps
module tb_mem_req_ctrl;

    localparam int DATA  = 18;
    localparam int ADDR  = 14;
    localparam int LEN   = 8;
    localparam int DEPTH = 1 << ADDR;

    logic            clka = 1'b0;
    logic            rst;
    logic            c0_req, c0_we;
    logic [ADDR-1:0] c0_addr;
    logic [DATA-1:0] c0_wdata;
    logic            c0_gnt, c0_rvalid;
    logic [DATA-1:0] c0_rdata;
    logic            c1_start;
    logic [ADDR-1:0] c1_addr;
    logic [LEN-1:0]  c1_len;
    logic            c1_busy, c1_valid, c1_done;
    logic [DATA-1:0] c1_data;
    logic            mem_we;
    logic [ADDR-1:0] mem_addr;
    logic [DATA-1:0] mem_din, mem_dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_req_ctrl #(.DATA(DATA), .ADDR(ADDR), .LEN(LEN)) dut (
        .clka(clka), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_start(c1_start), .c1_addr(c1_addr), .c1_len(c1_len),
        .c1_busy(c1_busy), .c1_valid(c1_valid), .c1_data(c1_data), .c1_done(c1_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clka = ~clka;
    always @(posedge clka) cyc <= cyc + 1;

    // Block RAM port: synchronous read, read-first on write, preloaded with mem[a] = a.
    logic [DATA-1:0] ram [DEPTH];
    bit ram_loaded;
    always @(posedge clka) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= DATA'(i);
            ram_loaded <= 1'b1;
        end else begin
            mem_dout <= ram[mem_addr];
            if (mem_we) ram[mem_addr] <= mem_din;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int              due;
        logic [DATA-1:0] data;
    } rsp_t;

    rsp_t            cq[$];
    rsp_t            sq[$];
    rsp_t            r;
    logic [DATA-1:0] sh [DEPTH];
    bit              sh_loaded;
    bit              s_active, rr_turn, want, exp_cpu, exp_str, ecv, esv, edone, last_gnt;
    int              s_start, s_len, s_issued, s_words, bursts_done;
    logic [ADDR-1:0] s_base, ea, exp_addr;

    always @(negedge clka) begin
        if (!sh_loaded) begin
            for (int i = 0; i < DEPTH; i++) sh[i] = DATA'(i);
            sh_loaded = 1'b1;
        end
        last_gnt = c0_gnt;
        if (rst) begin
            cq.delete();
            sq.delete();
            s_active = 1'b0;
            rr_turn  = 1'b0;
            chk("rst_ctrl", {c0_gnt, c0_rvalid, c1_busy, c1_valid, c1_done, mem_we}, 0);
            chk("rst_c0_rdata", c0_rdata, 0);
            chk("rst_c1_data", c1_data, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_din", mem_din, 0);
        end else begin
            want = s_active && (cyc > s_start) && (s_issued < s_len);
`ifdef MEM_REQ_RR_EN
            exp_cpu = c0_req && !(want && rr_turn);
            if (c0_req && want) rr_turn = exp_cpu;
`else
            exp_cpu = c0_req;
`endif
            exp_str  = want && !exp_cpu;
            ea       = s_base + ADDR'(s_issued);
            exp_addr = exp_cpu ? c0_addr : (exp_str ? ea : '0);
            chk("c0_gnt", c0_gnt, exp_cpu);
            chk("mem_we", mem_we, exp_cpu && c0_we);
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_din", mem_din, exp_cpu ? c0_wdata : '0);
            if (exp_cpu && !c0_we) cq.push_back('{cyc + 2, sh[c0_addr]});
            if (exp_cpu && c0_we) sh[c0_addr] = c0_wdata;
            if (exp_str) begin
                sq.push_back('{cyc + 2, sh[ea]});
                s_issued++;
            end

            ecv = (cq.size() > 0) && (cq[0].due == cyc);
            chk("c0_rvalid", c0_rvalid, ecv);
            if (ecv) begin
                r = cq.pop_front();
                chk("c0_rdata", c0_rdata, r.data);
            end

            esv = (sq.size() > 0) && (sq[0].due == cyc);
            chk("c1_valid", c1_valid, esv);
            edone = 1'b0;
            if (esv) begin
                r = sq.pop_front();
                s_words++;
                chk("c1_data", c1_data, r.data);
                edone = (s_words == s_len);
            end else begin
                edone = s_active && (s_len == 0) && (cyc == s_start + 2);
            end
            chk("c1_done", c1_done, edone);
            chk("c1_busy", c1_busy, s_active && (cyc > s_start));

            if (c1_start && !s_active) begin
                s_active = 1'b1;
                s_start  = cyc;
                s_base   = c1_addr;
                s_len    = int'(c1_len);
                s_issued = 0;
                s_words  = 0;
            end else if (edone) begin
                s_active = 1'b0;
                bursts_done++;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cpu_access(input logic we, input logic [ADDR-1:0] a, input logic [DATA-1:0] d,
                              output int glat, output int rlat, output logic [DATA-1:0] rd);
        int t0, g;
        glat = -1; rlat = -1; rd = '0; g = 0;
        @(posedge clka); #1;
        c0_req = 1'b1; c0_we = we; c0_addr = a; c0_wdata = d; t0 = cyc;
        for (int i = 0; i < 50; i++) begin
            @(negedge clka);
            if (c0_gnt) begin glat = cyc - t0; g = cyc; break; end
        end
        @(posedge clka); #1;
        c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
        if (!we && glat >= 0) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clka);
                if (c0_rvalid) begin rlat = cyc - g; rd = c0_rdata; break; end
            end
        end
    endtask

    task automatic run_burst(input logic [ADDR-1:0] base, input int len, input int exp_dur,
                             input string nm);
        int s, n, dcyc;
        logic ok;
        logic [ADDR-1:0] a;
        @(posedge clka); #1;
        c1_start = 1'b1; c1_addr = base; c1_len = len[LEN-1:0]; s = cyc;
        @(posedge clka); #1;
        c1_start = 1'b0; c1_addr = '0; c1_len = '0;
        n = 0; dcyc = -1; ok = 1'b1;
        for (int i = 0; i < 400 && dcyc < 0; i++) begin
            @(negedge clka);
            if (c1_valid) begin
                a = base + ADDR'(n);
                if (c1_data !== DATA'(a)) ok = 1'b0;
                n++;
            end
            if (c1_done) dcyc = cyc;
        end
        @(negedge clka);
        chk({nm, "_busy_after"}, c1_busy, 0);
        chk({nm, "_words"}, n, len);
        chk({nm, "_data"}, ok, 1);
        chk({nm, "_done_at"}, dcyc - s, exp_dur);
        $display("burst %s base=0x%0h len=%0d words=%0d done_after=%0d", nm, base, len, n, dcyc - s);
    endtask

    task automatic cpu_held_reads(input logic [ADDR-1:0] a0, input int n, output int grants);
        grants = 0;
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = a0;
        for (int i = 0; i < 40 && grants < n; i++) begin
            @(negedge clka);
            if (c0_gnt) grants++;
            @(posedge clka); #1;
            c0_addr = a0 + ADDR'(grants);
            if (grants >= n) begin c0_req = 1'b0; c0_addr = '0; end
        end
        c0_req = 1'b0;
    endtask

    typedef struct {
        logic            we;
        logic [ADDR-1:0] addr;
        logic [DATA-1:0] wdata;
        logic [DATA-1:0] exp;
    } vec_t;

    vec_t vt[8];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int glat, rlat, grants, n, cnt;
        logic [DATA-1:0] rd;

        vt[0] = '{1'b1, 14'h0010, 18'h2AAAA, 18'h00000};
        vt[1] = '{1'b0, 14'h0010, 18'h00000, 18'h2AAAA};
        vt[2] = '{1'b0, 14'h0011, 18'h00000, 18'h00011};
        vt[3] = '{1'b1, 14'h2000, 18'h3FFFF, 18'h00000};
        vt[4] = '{1'b0, 14'h2000, 18'h00000, 18'h3FFFF};
        vt[5] = '{1'b1, 14'h0010, 18'h15555, 18'h00000};
        vt[6] = '{1'b0, 14'h0010, 18'h00000, 18'h15555};
        vt[7] = '{1'b0, 14'h1234, 18'h00000, 18'h01234};

        rst = 1'b1;
        c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
        c1_start = 1'b0; c1_addr = '0; c1_len = '0;
        repeat (3) @(posedge clka);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            cpu_access(vt[i].we, vt[i].addr, vt[i].wdata, glat, rlat, rd);
            chk("tbl_gnt_lat", glat, 0);
            if (!vt[i].we) begin
                chk("tbl_rv_lat", rlat, 2);
                chk("tbl_rdata", rd, vt[i].exp);
            end
            $display("cpu %s addr=0x%0h wdata=0x%0h rdata=0x%0h", vt[i].we ? "WR" : "RD",
                     vt[i].addr, vt[i].wdata, rd);
        end

        // Write then read of the same word in the very next cycle.
        @(posedge clka); #1;
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 14'h0500; c0_wdata = 18'h0ABCD;
        @(negedge clka); chk("raw_wgnt", c0_gnt, 1);
        @(posedge clka); #1; c0_we = 1'b0; c0_wdata = '0;
        @(negedge clka); chk("raw_rgnt", c0_gnt, 1);
        @(posedge clka); #1; c0_req = 1'b0; c0_addr = '0;
        rd = '0; n = 0;
        for (int i = 0; i < 10 && n == 0; i++) begin
            @(negedge clka);
            if (c0_rvalid) begin rd = c0_rdata; n = 1; end
        end
        chk("raw_rdata", rd, 18'h0ABCD);
        $display("cpu RAW addr=0x500 rdata=0x%0h", rd);

        run_burst(14'h0100, 4, 6, "burst_basic");
        run_burst(14'h3FFE, 4, 6, "burst_wrap");
        run_burst(14'h0400, 0, 2, "burst_len0");

        fork
            run_burst(14'h0200, 8, 14, "burst_contend");
            begin
                repeat (3) @(posedge clka);
                #1;
                cpu_held_reads(14'h0300, 4, grants);
                chk("contend_cpu_grants", grants, 4);
                $display("cpu held reads base=0x300 grants=%0d", grants);
            end
        join
        repeat (4) @(posedge clka);

        // Reset in the middle of a long burst.
        @(posedge clka); #1;
        c1_start = 1'b1; c1_addr = 14'h0600; c1_len = 8'd16;
        @(posedge clka); #1;
        c1_start = 1'b0; c1_addr = '0; c1_len = '0;
        n = 0;
        for (int i = 0; i < 100 && n < 5; i++) begin
            @(negedge clka);
            if (c1_valid) n++;
        end
        chk("rst_mid_words_before", n, 5);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_c1_valid", c1_valid, 0);
        chk("rst_mid_c1_busy", c1_busy, 0);
        chk("rst_mid_c1_data", c1_data, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        repeat (2) @(posedge clka);
        #1 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clka);
            if (c1_valid || c1_done || c0_rvalid) cnt++;
        end
        chk("rst_mid_no_pulses", cnt, 0);
        $display("reset mid-burst after %0d words", n);
        run_burst(14'h0700, 16, 18, "burst_after_rst");

        // Random mixed traffic.
        for (int cy = 0; cy < 3000; cy++) begin
            @(posedge clka); #1;
            if (!c0_req || last_gnt) begin
                if ($urandom_range(0, 99) < 40) begin
                    c0_req   = 1'b1;
                    c0_we    = ($urandom_range(0, 1) == 1);
                    c0_addr  = ADDR'($urandom);
                    c0_wdata = DATA'($urandom);
                end else begin
                    c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
                end
            end
            c1_start = ($urandom_range(0, 39) == 0);
            if (c1_start) begin
                c1_addr = ($urandom_range(0, 3) == 0) ? ADDR'(16'h3FF0 + 16'($urandom_range(0, 15)))
                                                      : ADDR'($urandom);
                c1_len  = LEN'($urandom_range(0, 20));
            end else begin
                c1_addr = '0; c1_len = '0;
            end
        end
        @(posedge clka); #1;
        c0_req = 1'b0; c0_we = 1'b0; c1_start = 1'b0;
        repeat (80) @(posedge clka);
        $display("random phase complete, bursts finished=%0d", bursts_done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
